// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one single-port memory between the fetch
// and data requesters, with a fixed-latency access and registered read data.
module mem_port_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [3:0] LATC   = 4'(LAT);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        last;
    logic        own;
    logic        we_r;
    logic        byte_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        grant;
    logic        pick;

    // pick: 1 selects the data port; a tie goes to whoever was not served last
    always_comb begin
        grant = if_req | dm_req;
        pick  = (if_req & dm_req) ? ~last : dm_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            last     <= 1'b1;
            own      <= 1'b0;
            we_r     <= 1'b0;
            byte_r   <= 1'b0;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            if_rdata <= 32'd0;
            dm_rdata <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        own     <= pick;
                        addr_r  <= pick ? dm_addr : if_addr;
                        wdata_r <= pick ? dm_wdata : wdata_r;
                        we_r    <= pick & dm_we;
                        byte_r  <= pick & dm_byte;
                        cnt     <= LATC;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!we_r) begin
                            if (own) dm_rdata <= mem_rdata;
                            else     if_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    last  <= own;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // write strobe only on the first access cycle so a store writes once
    always_comb begin
        mem_en    = (state == ACCESS);
        mem_we    = mem_en & we_r & (cnt == LATC);
        mem_byte  = mem_en & byte_r;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        if_ack    = (state == RESP) & ~own;
        dm_ack    = (state == RESP) & own;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: vector table, corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic        dm_byte = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;

    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_en, mem_we, mem_byte, busy;

    logic [31:0] z_if_rdata, z_dm_rdata, z_mem_addr, z_mem_wdata;
    logic [31:0] z_mrd = 32'h000000FF;
    logic        z_if_ack, z_dm_ack, z_mem_en, z_mem_we, z_mem_byte, z_busy;

    logic [5:0] ctl0, z_ctl;
    assign ctl0  = {mem_en, mem_we, mem_byte, if_ack, dm_ack, busy};
    assign z_ctl = {z_mem_en, z_mem_we, z_mem_byte, z_if_ack, z_dm_ack, z_busy};

    always #5 clk = ~clk;

    mem_port_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.LAT(0)) dz (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(z_if_rdata), .if_ack(z_if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(z_dm_rdata), .dm_ack(z_dm_ack),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_byte(z_mem_byte),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_rdata(z_mrd),
        .busy(z_busy)
    );

    // environment memory: 16 words, preset contents until written
    bit [15:0]   wv;
    logic [31:0] wd [16];

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h3C010001 : 32'h1000_0000 + 32'(i) * 32'h111;
    endfunction

    always_comb begin
        mem_rdata = wv[mem_addr[5:2]] ? wd[mem_addr[5:2]]
                                      : init_word(int'(mem_addr[5:2]));
    end

    always @(posedge clk) begin
        if (mem_we) begin
            wv[mem_addr[5:2]] <= 1'b1;
            wd[mem_addr[5:2]] <= mem_wdata;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        r;
        logic        ir;
        logic        dr;
        logic        dw;
        logic [5:0]  ctl;
        logic [31:0] ifr;
        logic [31:0] dmr;
    } vec_t;

    function automatic vec_t v(input logic r, ir, dr, dw, input logic [5:0] ctl,
                               input logic [31:0] ifr, dmr);
        vec_t t;
        t.r = r; t.ir = ir; t.dr = dr; t.dw = dw;
        t.ctl = ctl; t.ifr = ifr; t.dmr = dmr;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        logic [31:0] F, D;
        int acks;
        logic [31:0] refmem [16];
        int g_cyc, k, idx;
        logic g_own, g_we, g_byte, m_last, if_seen, dm_seen;
        logic [31:0] g_addr, g_wd, g_exp, ifr_e, dmr_e;
        logic [5:0] ectl;
        logic e_en, e_we;

        F = 32'h3C010001;
        D = 32'hDEADBEEF;
        // fetch, then store, then reset and both requesters held high
        tbl.push_back(v(1, 1, 0, 0, 6'b000000, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 0, 0, 6'b100001, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 6'b000101, F, 0));
        tbl.push_back(v(1, 0, 1, 1, 6'b000000, F, 0));
        tbl.push_back(v(1, 0, 1, 1, 6'b110001, F, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 0, 1, 1, 6'b100001, F, 0));
        tbl.push_back(v(1, 0, 1, 1, 6'b000011, F, 0));
        tbl.push_back(v(1, 0, 0, 0, 6'b000000, F, 0));
        tbl.push_back(v(0, 0, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 6'b000000, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 1, 0, 6'b100001, 0, 0));
        tbl.push_back(v(1, 1, 1, 0, 6'b000101, F, 0));
        tbl.push_back(v(1, 1, 1, 0, 6'b000000, F, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 1, 0, 6'b100001, F, 0));
        tbl.push_back(v(1, 1, 1, 0, 6'b000011, F, D));
        tbl.push_back(v(1, 1, 1, 0, 6'b000000, F, D));
        for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 1, 0, 6'b100001, F, D));
        tbl.push_back(v(1, 1, 1, 0, 6'b000101, F, D));
        tbl.push_back(v(1, 0, 0, 0, 6'b000000, F, D));

        if_addr  = 32'h00003000;
        dm_addr  = 32'h00000010;
        dm_wdata = D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 32'(ctl0), 32'd0);
        chk("rst_ifr", if_rdata, 32'd0);
        chk("rst_dmr", dm_rdata, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);

        foreach (tbl[i]) begin
            step();
            rst = tbl[i].r;
            if_req = tbl[i].ir;
            dm_req = tbl[i].dr;
            dm_we = tbl[i].dw;
            @(negedge clk);
            chk($sformatf("tbl%0d_ctl", i), 32'(ctl0), 32'(tbl[i].ctl));
            chk($sformatf("tbl%0d_ifr", i), if_rdata, tbl[i].ifr);
            chk($sformatf("tbl%0d_dmr", i), dm_rdata, tbl[i].dmr);
        end

        // byte load on the LAT=0 instance
        step(); rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        step(); rst = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b1;
        dm_addr = 32'h20;
        @(negedge clk); chk("z_c0", 32'(z_ctl), 32'd0);
        step(); @(negedge clk);
        chk("z_c1", 32'(z_ctl), 32'(6'b101001));
        chk("lat2_byte", 32'(ctl0), 32'(6'b101001));
        step(); @(negedge clk);
        chk("z_c2", 32'(z_ctl), 32'(6'b000011));
        chk("z_dmr", z_dm_rdata, 32'h000000FF);
        step(); dm_req = 1'b0; dm_byte = 1'b0;
        @(negedge clk);
        chk("z_c3", 32'(z_ctl), 32'd0);
        chk("z_dmr_hold", z_dm_rdata, 32'h000000FF);

        // reset in the middle of a store
        step(); rst = 1'b0;
        step(); rst = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 32'h30; dm_wdata = 32'hA5A55A5A;
        step(); @(negedge clk);
        chk("st_c1", 32'(ctl0), 32'(6'b110001));
        chk("st_wdata", mem_wdata, 32'hA5A55A5A);
        step(); @(negedge clk);
        chk("st_c2", 32'(ctl0), 32'(6'b100001));
        rst = 1'b0;
        #1;
        chk("st_abort", 32'(ctl0), 32'd0);
        step(); rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acks += int'(dm_ack);
        end
        chk("st_no_ack", 32'(acks), 32'd0);
        step(); dm_req = 1'b1;
        step(); @(negedge clk);
        chk("fresh_c1", 32'(ctl0), 32'(6'b100001));
        step(); step(); step(); @(negedge clk);
        chk("fresh_c4", 32'(ctl0), 32'(6'b000011));
        chk("fresh_dmr", dm_rdata, 32'hA5A55A5A);
        step(); dm_req = 1'b0;

        // fetch request withdrawn during ACCESS still completes
        step(); if_req = 1'b1; if_addr = 32'h24;
        step();
        step(); if_req = 1'b0;
        step(); step(); @(negedge clk);
        chk("drop_ack", 32'(ctl0), 32'(6'b000101));
        chk("drop_ifr", if_rdata, init_word(9));

        // randomized traffic against a transaction-level model
        step(); rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        step(); rst = 1'b1;
        for (int i = 0; i < 16; i++) refmem[i] = wv[i] ? wd[i] : init_word(i);
        g_cyc = -100; m_last = 1'b1; ifr_e = 0; dmr_e = 0;
        g_own = 0; g_we = 0; g_byte = 0; g_addr = 0; g_wd = 0; g_exp = 0;
        if_seen = 0; dm_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (if_seen) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (dm_seen) dm_req = 1'b0;
            else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_addr = $urandom; dm_wdata = $urandom;
                dm_we = 1'($urandom); dm_byte = 1'($urandom);
            end
            @(negedge clk);
            k = c - g_cyc;
            if (k > LAT + 2 && (if_req || dm_req)) begin
                g_own = (if_req && dm_req) ? ~m_last : dm_req;
                g_cyc = c; k = 0;
                g_we = g_own & dm_we;
                g_byte = g_own & dm_byte;
                g_addr = g_own ? dm_addr : if_addr;
                g_wd = dm_wdata;
                idx = int'(g_addr[5:2]);
                if (g_we) refmem[idx] = g_wd;
                else g_exp = refmem[idx];
            end
            e_en = (k >= 1 && k <= LAT + 1);
            e_we = e_en && k == 1 && g_we;
            ectl = {e_en, e_we, e_en & g_byte, k == LAT + 2 && !g_own,
                    k == LAT + 2 && g_own, k >= 1 && k <= LAT + 2};
            if (k == LAT + 2) begin
                m_last = g_own;
                if (!g_we) begin
                    if (g_own) dmr_e = g_exp;
                    else ifr_e = g_exp;
                end
            end
            chk($sformatf("rnd%0d_ctl", c), 32'(ctl0), 32'(ectl));
            chk($sformatf("rnd%0d_ifr", c), if_rdata, ifr_e);
            chk($sformatf("rnd%0d_dmr", c), dm_rdata, dmr_e);
            if (e_en) chk($sformatf("rnd%0d_addr", c), mem_addr, g_addr);
            if (e_we) chk($sformatf("rnd%0d_wdata", c), mem_wdata, g_wd);
            if_seen = if_ack;
            dm_seen = dm_ack;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
